// File: rtl/ball_controller.sv
`default_nettype none
// ============================================================================
// Module   : ball_controller
// Purpose  : Pong ball motion, paddle reflection and scoring FSM, stepped once
//            per frame_tick.
// Revision : 1.0
// ============================================================================
module ball_controller #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned BALL_SIZE   = 10,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned PADDLE_L_X  = 16,
  parameter int unsigned PADDLE_R_X  = 616,
  parameter int unsigned PADDLE_W    = 8,
  parameter int unsigned PADDLE_H    = 60,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_pos_x,
  output logic [9:0] ball_pos_y,
  output logic       score_l,
  output logic       score_r,
  output logic       in_play
);

  localparam logic [9:0]  c_center_x = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  c_center_y = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0]  c_speed    = 10'(SPEED);
  localparam logic [9:0]  c_bottom_y = 10'(SCREEN_H - 1 - BALL_SIZE);
  localparam logic [9:0]  c_right_x  = 10'(SCREEN_W - 1 - BALL_SIZE);
  localparam logic [9:0]  c_l_hit_x  = 10'(PADDLE_L_X + PADDLE_W);
  localparam logic [9:0]  c_r_hit_x  = 10'(PADDLE_R_X - 1 - BALL_SIZE);
  localparam logic [10:0] c_ball_w   = 11'(BALL_SIZE);
  localparam logic [10:0] c_speed_w  = 11'(SPEED);
  localparam logic [10:0] c_scr_w_m1 = 11'(SCREEN_W - 1);
  localparam logic [10:0] c_scr_h_m1 = 11'(SCREEN_H - 1);
  localparam logic [10:0] c_l_face   = 11'(PADDLE_L_X + PADDLE_W - 1);
  localparam logic [10:0] c_r_col    = 11'(PADDLE_R_X);
  localparam logic [10:0] c_pad_h_m1 = 11'(PADDLE_H - 1);
  localparam int          c_cnt_w    = $clog2(HOLD_FRAMES + 1);
  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2
  } state_t;

  state_t             state_q;
  logic [9:0]         x_q, y_q, x_d, y_d;
  logic               dx_q, dy_q, dx_d, dy_d;
  logic               pend_q;
  logic [c_cnt_w-1:0] cnt_q;
  logic               score_l_q, score_r_q, in_play_q;
  logic               miss_left, miss_right;
  logic [10:0]        x_w, y_w, pl_w, pr_w;
  logic               ovl_l, ovl_r;

  // 11-bit views so that edge sums and differences never wrap.
  assign x_w  = {1'b0, x_q};
  assign y_w  = {1'b0, y_q};
  assign pl_w = {1'b0, paddle_l_y};
  assign pr_w = {1'b0, paddle_r_y};

  assign ovl_l = (y_w + c_ball_w >= pl_w) && (y_w <= pl_w + c_pad_h_m1);
  assign ovl_r = (y_w + c_ball_w >= pr_w) && (y_w <= pr_w + c_pad_h_m1);

  always_comb begin
    y_d  = y_q;
    dy_d = dy_q;
    if (!dy_q) begin
      if (y_w + c_ball_w + c_speed_w >= c_scr_h_m1) begin
        y_d  = c_bottom_y;
        dy_d = 1'b1;
      end else begin
        y_d = y_q + c_speed;
      end
    end else begin
      if (y_w < c_speed_w) begin
        y_d  = 10'd0;
        dy_d = 1'b0;
      end else begin
        y_d = y_q - c_speed;
      end
    end
  end

  // Paddle hits are tested before misses so a ball reaching both wins the hit.
  always_comb begin
    x_d        = x_q;
    dx_d       = dx_q;
    miss_left  = 1'b0;
    miss_right = 1'b0;
    if (dx_q) begin
      if ((x_w > c_l_face) && (x_w - c_speed_w <= c_l_face) && ovl_l) begin
        x_d  = c_l_hit_x;
        dx_d = 1'b0;
      end else if (x_w < c_speed_w) begin
        x_d       = 10'd0;
        dx_d      = 1'b1;
        miss_left = 1'b1;
      end else begin
        x_d = x_q - c_speed;
      end
    end else begin
      if ((x_w + c_ball_w < c_r_col) && (x_w + c_ball_w + c_speed_w >= c_r_col) && ovl_r) begin
        x_d  = c_r_hit_x;
        dx_d = 1'b1;
      end else if (x_w + c_ball_w + c_speed_w > c_scr_w_m1) begin
        x_d        = c_right_x;
        dx_d       = 1'b0;
        miss_right = 1'b1;
      end else begin
        x_d = x_q + c_speed;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= c_center_x;
      y_q       <= c_center_y;
      dx_q      <= 1'b0;
      dy_q      <= 1'b0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
      in_play_q <= 1'b0;
    end else begin
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_tick && pend_q) begin
            state_q   <= PLAY;
            pend_q    <= 1'b0;
            in_play_q <= 1'b1;
          end else if (serve) begin
            pend_q <= 1'b1;
          end
        end
        PLAY: begin
          if (frame_tick) begin
            x_q  <= x_d;
            y_q  <= y_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            if (miss_left || miss_right) begin
              state_q   <= SCORED;
              in_play_q <= 1'b0;
              score_r_q <= miss_left;
              score_l_q <= miss_right;
            end
          end
        end
        SCORED: begin
          if (frame_tick) begin
            if (cnt_q == c_hold_last) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              x_q     <= c_center_x;
              y_q     <= c_center_y;
              dy_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          in_play_q <= 1'b0;
        end
      endcase
    end
  end

  assign ball_pos_x = x_q;
  assign ball_pos_y = y_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign in_play    = in_play_q;

endmodule
`default_nettype wire

// File: tb/tb_ball_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_controller
// Purpose  : Directed and randomized scoreboard bench for ball_controller.
// Revision : 1.0
// ============================================================================
module tb_ball_controller;

  localparam int SW = 640, SH = 480, BS = 10, SP = 2;
  localparam int LX = 16, RX = 616, PW = 8, PH = 60, HOLD = 60;
  localparam int CX = (SW - BS) / 2, CY = (SH - BS) / 2;
  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_SCORED = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1, frame_tick = 1'b0, serve = 1'b0;
  logic [9:0] paddle_l_y = 10'd0, paddle_r_y = 10'd0;
  logic [9:0] ball_pos_x, ball_pos_y;
  logic       score_l, score_r, in_play;

  ball_controller dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .serve      (serve),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .ball_pos_x (ball_pos_x),
    .ball_pos_y (ball_pos_y),
    .score_l    (score_l),
    .score_r    (score_r),
    .in_play    (in_play)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int ip; int sl; int sr; } exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0;

  // Reference game state, stepped from the rules in plain integer arithmetic.
  int m_st = ST_IDLE, m_x = CX, m_y = CY, m_dx = 0, m_dy = 0, m_pend = 0, m_hold = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic model(input bit tk, input bit sv, input bit rs, input int pl, input int pr);
    exp_t e;
    int nx, ny, ndx, ndy;
    bit hit;
    e.sl = 0;
    e.sr = 0;
    if (rs) begin
      m_st = ST_IDLE; m_x = CX; m_y = CY; m_dx = 0; m_dy = 0; m_pend = 0; m_hold = 0;
    end else if (!tk) begin
      if (m_st == ST_IDLE && sv) m_pend = 1;
      return;
    end else if (m_st == ST_IDLE) begin
      if (m_pend != 0) begin
        m_st = ST_PLAY;
        m_pend = 0;
      end else if (sv) begin
        m_pend = 1;
      end
    end else if (m_st == ST_SCORED) begin
      m_hold++;
      if (m_hold == HOLD) begin
        m_st = ST_IDLE; m_x = CX; m_y = CY; m_dy = 0; m_hold = 0;
      end
    end else begin
      ny  = (m_dy != 0) ? m_y - SP : m_y + SP;
      ndy = m_dy;
      if (m_dy == 0 && ny + BS >= SH - 1) begin
        ny = SH - 1 - BS; ndy = 1;
      end else if (m_dy != 0 && ny < 0) begin
        ny = 0; ndy = 0;
      end
      nx  = (m_dx != 0) ? m_x - SP : m_x + SP;
      ndx = m_dx;
      if (m_dx != 0) begin
        hit = (m_x >= LX + PW) && (nx < LX + PW) && (m_y + BS >= pl) && (m_y < pl + PH);
        if (hit) begin
          nx = LX + PW; ndx = 0;
        end else if (nx < 0) begin
          nx = 0; e.sr = 1; m_st = ST_SCORED;
        end
      end else begin
        hit = (m_x + BS < RX) && (nx + BS >= RX) && (m_y + BS >= pr) && (m_y < pr + PH);
        if (hit) begin
          nx = RX - 1 - BS; ndx = 1;
        end else if (nx + BS > SW - 1) begin
          nx = SW - 1 - BS; e.sl = 1; m_st = ST_SCORED;
        end
      end
      m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
    end
    e.x  = m_x;
    e.y  = m_y;
    e.ip = (m_st == ST_PLAY) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit tk, input bit sv, input bit rs);
    frame_tick = tk;
    serve      = sv;
    reset      = rs;
    @(posedge clk);
    model(tk, sv, rs, int'(paddle_l_y), int'(paddle_r_y));
    #1;
    frame_tick = 1'b0;
    serve      = 1'b0;
    reset      = 1'b0;
  endtask

  function automatic int far_y(input int y);
    return (y > 240) ? 0 : 400;
  endfunction

  task automatic set_paddles(input bit lfar, input bit rfar);
    paddle_l_y = 10'(lfar ? far_y(m_y) : m_y);
    paddle_r_y = 10'(rfar ? far_y(m_y) : m_y);
  endtask

  task automatic play_tick(input bit lfar, input bit rfar);
    set_paddles(lfar, rfar);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [9:0] rnd_paddle(input int y);
    int p;
    if ($urandom_range(0, 4) != 0) begin
      p = y - int'($urandom_range(0, 50));
      if (p < 0) p = 0;
    end else begin
      p = int'($urandom_range(0, 1023));
    end
    return 10'(p);
  endfunction

  // Monitor: every reset or tick edge leaves one expectation to retire.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("x", int'(ball_pos_x), e.x);
      chk("y", int'(ball_pos_y), e.y);
      chk("in_play", int'(in_play), e.ip);
      chk("score_l", int'(score_l), e.sl);
      chk("score_r", int'(score_r), e.sr);
    end else begin
      chk("pulse_quiet", int'({score_l, score_r}), 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("rst_x", int'(ball_pos_x), 315);
    chk("rst_y", int'(ball_pos_y), 235);
    chk("rst_in_play", int'(in_play), 0);

    // Serve then three ticks: first tick only enters play.
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("serve_in_play", int'(in_play), 1);
    chk("serve_x0", int'(ball_pos_x), 315);
    cycle(1'b0, 1'b0, 1'b0);
    play_tick(1'b0, 1'b0);
    chk("move_x1", int'(ball_pos_x), 317);
    chk("move_y1", int'(ball_pos_y), 237);
    play_tick(1'b0, 1'b0);
    chk("move_x2", int'(ball_pos_x), 319);
    chk("move_y2", int'(ball_pos_y), 239);

    // Bottom wall bounce from y=468 going down.
    for (int i = 0; i < 3000 && !(m_st == ST_PLAY && m_y == 468 && m_dy == 0); i++)
      play_tick(1'b0, 1'b0);
    chk("reach_y468", int'(ball_pos_y), 468);
    play_tick(1'b0, 1'b0);
    chk("bottom_y469", int'(ball_pos_y), 469);
    play_tick(1'b0, 1'b0);
    chk("bottom_y467", int'(ball_pos_y), 467);

    // Left paddle hit: moving left at x=25 lands on the paddle face at 24.
    for (int i = 0; i < 3000 && !(m_st == ST_PLAY && m_x == 25 && m_dx == 1); i++)
      play_tick(1'b0, 1'b0);
    chk("reach_x25", int'(ball_pos_x), 25);
    play_tick(1'b0, 1'b0);
    chk("lhit_x24", int'(ball_pos_x), 24);
    chk("lhit_in_play", int'(in_play), 1);
    play_tick(1'b0, 1'b0);
    chk("lhit_x26", int'(ball_pos_x), 26);

    // Right paddle hit at x=604.
    for (int i = 0; i < 3000 && !(m_st == ST_PLAY && m_x == 604 && m_dx == 0); i++)
      play_tick(1'b0, 1'b0);
    chk("reach_x604", int'(ball_pos_x), 604);
    play_tick(1'b0, 1'b0);
    chk("rhit_x605", int'(ball_pos_x), 605);
    play_tick(1'b0, 1'b0);
    chk("rhit_x603", int'(ball_pos_x), 603);

    // Right miss from x=628, then the hold period.
    for (int i = 0; i < 3000 && !(m_st == ST_PLAY && m_x == 628 && m_dx == 0); i++)
      play_tick(1'b0, 1'b1);
    chk("reach_x628", int'(ball_pos_x), 628);
    set_paddles(1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("rmiss_score_l", int'(score_l), 1);
    chk("rmiss_x629", int'(ball_pos_x), 629);
    chk("rmiss_in_play", int'(in_play), 0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("rmiss_pulse_end", int'(score_l), 0);
    for (int i = 0; i < HOLD - 1; i++) play_tick(1'b0, 1'b0);
    chk("hold59_x", int'(ball_pos_x), 629);
    play_tick(1'b0, 1'b0);
    chk("hold60_x", int'(ball_pos_x), 315);
    chk("hold60_y", int'(ball_pos_y), 235);
    cycle(1'b0, 1'b1, 1'b0);
    play_tick(1'b0, 1'b0);
    play_tick(1'b0, 1'b0);
    chk("reserve_right_x", int'(ball_pos_x), 317);

    // Left miss from x=1 with serve held through the hold period.
    for (int i = 0; i < 3000 && !(m_st == ST_PLAY && m_x == 1 && m_dx == 1); i++)
      play_tick(1'b1, 1'b0);
    chk("reach_x1", int'(ball_pos_x), 1);
    set_paddles(1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("lmiss_score_r", int'(score_r), 1);
    chk("lmiss_x0", int'(ball_pos_x), 0);
    chk("lmiss_in_play", int'(in_play), 0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("lmiss_pulse_end", int'(score_r), 0);
    for (int i = 0; i < HOLD; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, (i < HOLD - 1), 1'b0);
    end
    chk("lhold_x", int'(ball_pos_x), 315);
    cycle(1'b1, 1'b0, 1'b0);
    chk("no_serve_latched", int'(in_play), 0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("lserve_in_play", int'(in_play), 1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("reserve_left_x", int'(ball_pos_x), 313);

    // Reset coinciding with a tick in the middle of the hold period.
    for (int i = 0; i < 3000 && m_st != ST_SCORED; i++) play_tick(1'b1, 1'b0);
    chk("reach_scored", int'(in_play), 0);
    for (int i = 0; i < 5; i++) play_tick(1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    chk("mid_rst_x", int'(ball_pos_x), 315);
    chk("mid_rst_y", int'(ball_pos_y), 235);
    chk("mid_rst_in_play", int'(in_play), 0);
    chk("mid_rst_scores", int'({score_l, score_r}), 0);
    play_tick(1'b0, 1'b0);
    chk("mid_rst_needs_serve", int'(in_play), 0);
    cycle(1'b0, 1'b1, 1'b0);
    play_tick(1'b0, 1'b0);
    chk("mid_rst_served", int'(in_play), 1);

    // Randomized play: mostly-tracking paddles, random serves, rare resets.
    for (int i = 0; i < 15000; i++) begin
      paddle_l_y = rnd_paddle(m_y);
      paddle_r_y = rnd_paddle(m_y);
      cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2999) == 0));
    end

    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
